bram_serial_tx: RTL and testbench

- Host-side transmitter for the two-wire serial BRAM loader (serial clock + serial data) consumed by the VGA/BRAM test design.
- Accepts bytes over a valid/ready stream and serialises each one MSB-first.
- Toggles the serial clock once per bit, so every edge, rising or falling, carries one bit.
- Counts bytes so the host knows when a full BRAM image (TOTAL_BYTES) has been sent; paces bits and bytes slowly enough for the receiver's 3-flop synchroniser and its 6-cycle write sequence.

---
 rtl/bram_serial_tx_pkg.sv | 25 ++
 rtl/bram_serial_tx_phase_timer.sv | 40 ++++
 rtl/bram_serial_tx.sv | 264 ++++++++++++++++++++++++++
 tb/tb_bram_serial_tx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_serial_tx_pkg.sv
// Shared types and default constants for the serial BRAM loader transmitter.
package bram_serial_tx_pkg;

    // Transmitter FSM states; PRE_RST is only reachable when the target-reset
    // feature is compiled in.
    typedef enum logic [2:0] {
        PRE_RST,
        IDLE,
        SETUP,
        HOLD,
        GAP,
        DONE
    } tx_state_t;

    localparam int HALF_BIT_DEF    = 4;
    localparam int BYTE_GAP_DEF    = 16;
    localparam int TOTAL_BYTES_DEF = 8192;   // 8 BRAMs x 1024 bytes
    localparam int CNT_W_DEF       = 14;
    localparam int RST_CYCLES_DEF  = 8;
    localparam int BITS_PER_BYTE   = 8;

    // Width of the shared phase timer; every phase length must fit in it.
    localparam int TIMER_W         = 16;

endpackage

// File: rtl/bram_serial_tx_phase_timer.sv
// Loadable down-counter with a terminal-count flag, shared by all timed
// phases of the transmitter (bit setup, bit hold, byte gap, target reset).
module tx_phase_timer
    import bram_serial_tx_pkg::*;
#(
    parameter int                 W          = TIMER_W,
    parameter logic [W-1:0]       RST_VAL    = '0,
    parameter bit                 RST_ACTIVE = 1'b0
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;
    logic         r_active;

    // Count down from the loaded value; the phase ends on the cycle the
    // count sits at zero, after which the timer goes quiet until reloaded.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt    <= RST_VAL;
            r_active <= RST_ACTIVE;
        end else if (i_load) begin
            r_cnt    <= i_load_val;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_cnt == '0) begin
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_tc = r_active && (r_cnt == '0);

endmodule

// File: rtl/bram_serial_tx.sv
// Host-side transmitter for the two-wire serial BRAM loader. Each accepted
// byte is sent MSB-first; sclk toggles once per bit so both edges carry data.
// Optional feature macro: BRAM_SERIAL_TX_TARGET_RST_EN adds the target_rst
// output, the RST_CYCLES parameter and the PRE_RST sequence.
module bram_serial_tx
    import bram_serial_tx_pkg::*;
#(
    parameter int HALF_BIT    = HALF_BIT_DEF,
    parameter int BYTE_GAP    = BYTE_GAP_DEF,
    parameter int TOTAL_BYTES = TOTAL_BYTES_DEF,
    parameter int CNT_W       = CNT_W_DEF
`ifdef BRAM_SERIAL_TX_TARGET_RST_EN
    ,
    parameter int RST_CYCLES  = RST_CYCLES_DEF
`endif
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             restart,
    output logic             sclk,
    output logic             sdata,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] byte_count
`ifdef BRAM_SERIAL_TX_TARGET_RST_EN
    ,
    output logic             target_rst
`endif
);

    // The receiver needs a 3-flop synchroniser margin on each side of a
    // toggle and time for its 6-cycle write between bytes.
    if (HALF_BIT < 3) begin : g_chk_half_bit
        $error("bram_serial_tx: HALF_BIT must be >= 3");
    end
    if (BYTE_GAP < 8) begin : g_chk_byte_gap
        $error("bram_serial_tx: BYTE_GAP must be >= 8");
    end
    if (TOTAL_BYTES >= (1 << CNT_W)) begin : g_chk_cnt_w
        $error("bram_serial_tx: CNT_W too narrow for TOTAL_BYTES");
    end

    localparam logic [TIMER_W-1:0] HB_LOAD   = TIMER_W'(HALF_BIT - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(BYTE_GAP - 1);
    localparam logic [CNT_W-1:0]   TOTAL_C   = CNT_W'(TOTAL_BYTES);
    localparam logic [2:0]         LAST_IDX  = 3'(BITS_PER_BYTE - 1);
`ifdef BRAM_SERIAL_TX_TARGET_RST_EN
    localparam logic [TIMER_W-1:0] RC_LOAD   = TIMER_W'(RST_CYCLES - 1);
    // The timer comes out of reset already timing the first target-reset phase.
    localparam logic [TIMER_W-1:0] TMR_RST   = RC_LOAD;
    localparam bit                 TMR_RST_A = 1'b1;
    localparam tx_state_t          ST_RST    = PRE_RST;
`else
    localparam logic [TIMER_W-1:0] TMR_RST   = '0;
    localparam bit                 TMR_RST_A = 1'b0;
    localparam tx_state_t          ST_RST    = IDLE;
`endif

    tx_state_t          r_state;
    logic [7:0]         r_shreg;
    logic [2:0]         r_bit_idx;
    logic               r_sclk;
    logic               r_sdata;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W-1:0]   r_count;
`ifdef BRAM_SERIAL_TX_TARGET_RST_EN
    logic               r_target_rst;
    logic               r_rst_phase;    // 0: target_rst high half, 1: low half
`endif

    logic               w_in_ready;
    logic               w_accept;
    logic               w_tmr_load;
    logic [TIMER_W-1:0] w_tmr_val;
    logic               w_tmr_tc;
    logic [CNT_W-1:0]   w_count_inc;

    // restart wins over a simultaneous in_valid, so ready is withdrawn that cycle.
    assign w_in_ready  = r_ready && !restart;
    assign w_accept    = (r_state == IDLE) && in_valid && w_in_ready;
    assign w_count_inc = (r_count == TOTAL_C) ? r_count : r_count + 1'b1;

    // Decide when the phase timer is (re)loaded and with which phase length.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = HB_LOAD;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_tmr_load = 1'b1;
                end
`ifdef BRAM_SERIAL_TX_TARGET_RST_EN
                if (restart) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = RC_LOAD;
                end
`endif
            end
            SETUP: begin
                if (w_tmr_tc) begin
                    w_tmr_load = 1'b1;
                end
            end
            HOLD: begin
                if (w_tmr_tc) begin
                    w_tmr_load = 1'b1;
                    if (r_bit_idx == 3'd0) begin
                        w_tmr_val = GAP_LOAD;
                    end
                end
            end
`ifdef BRAM_SERIAL_TX_TARGET_RST_EN
            DONE: begin
                if (restart) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = RC_LOAD;
                end
            end
            PRE_RST: begin
                if (w_tmr_tc && !r_rst_phase) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = RC_LOAD;
                end
            end
`endif
            default: ;
        endcase
    end

    tx_phase_timer #(
        .W          (TIMER_W),
        .RST_VAL    (TMR_RST),
        .RST_ACTIVE (TMR_RST_A)
    ) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_tc       (w_tmr_tc)
    );

    // Main FSM: byte acceptance, bit serialisation, byte gap and image count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_RST;
            r_shreg      <= '0;
            r_bit_idx    <= '0;
            r_sclk       <= 1'b0;
            r_sdata      <= 1'b0;
            r_ready      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_count      <= '0;
`ifdef BRAM_SERIAL_TX_TARGET_RST_EN
            r_target_rst <= 1'b1;
            r_rst_phase  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (restart) begin
                        r_count <= '0;
`ifdef BRAM_SERIAL_TX_TARGET_RST_EN
                        r_state      <= PRE_RST;
                        r_ready      <= 1'b0;
                        r_target_rst <= 1'b1;
                        r_rst_phase  <= 1'b0;
`else
                        r_ready <= 1'b1;
`endif
                    end else if (w_accept) begin
                        r_shreg   <= in_data;
                        r_sdata   <= in_data[7];
                        r_bit_idx <= LAST_IDX;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= SETUP;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    // sdata has been stable HALF_BIT cycles: clock it out.
                    if (w_tmr_tc) begin
                        r_sclk  <= ~r_sclk;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_tmr_tc) begin
                        r_shreg <= r_shreg << 1;
                        if (r_bit_idx == 3'd0) begin
                            r_state <= GAP;
                        end else begin
                            r_bit_idx <= r_bit_idx - 1'b1;
                            r_sdata   <= r_shreg[6];
                            r_state   <= SETUP;
                        end
                    end
                end
                GAP: begin
                    if (w_tmr_tc) begin
                        r_busy  <= 1'b0;
                        r_count <= w_count_inc;
                        if (w_count_inc == TOTAL_C) begin
                            r_done  <= 1'b1;
                            r_ready <= 1'b0;
                            r_state <= DONE;
                        end else begin
                            r_ready <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                DONE: begin
                    if (restart) begin
                        r_count <= '0;
                        r_done  <= 1'b0;
`ifdef BRAM_SERIAL_TX_TARGET_RST_EN
                        r_state      <= PRE_RST;
                        r_target_rst <= 1'b1;
                        r_rst_phase  <= 1'b0;
`else
                        r_ready <= 1'b1;
                        r_state <= IDLE;
`endif
                    end
                end
`ifdef BRAM_SERIAL_TX_TARGET_RST_EN
                PRE_RST: begin
                    if (w_tmr_tc) begin
                        if (!r_rst_phase) begin
                            r_target_rst <= 1'b0;
                            r_rst_phase  <= 1'b1;
                        end else begin
                            r_ready <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign sclk       = r_sclk;
    assign sdata      = r_sdata;
    assign busy       = r_busy;
    assign done       = r_done;
    assign byte_count = r_count;
`ifdef BRAM_SERIAL_TX_TARGET_RST_EN
    assign target_rst = r_target_rst;
`endif

endmodule

// File: tb/tb_bram_serial_tx.sv
// Directed bench for bram_serial_tx with a small receiver model attached.
// Builds with or without BRAM_SERIAL_TX_TARGET_RST_EN.
module tb_bram_serial_tx;

    localparam int TB_TOTAL = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        restart;
    logic        sclk;
    logic        sdata;
    logic        busy;
    logic        done;
    logic [13:0] byte_count;
`ifdef BRAM_SERIAL_TX_TARGET_RST_EN
    logic        target_rst;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int exp_count = 0;
    logic [7:0] sent_q[$];

    always #5 clk = ~clk;

    bram_serial_tx #(
        .HALF_BIT    (4),
        .BYTE_GAP    (16),
        .TOTAL_BYTES (TB_TOTAL),
        .CNT_W       (14)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .restart    (restart),
        .sclk       (sclk),
        .sdata      (sdata),
        .busy       (busy),
        .done       (done),
        .byte_count (byte_count)
`ifdef BRAM_SERIAL_TX_TARGET_RST_EN
        ,
        .target_rst (target_rst)
`endif
    );

    // Receiver model: 3-flop synchronisers on both wires, capture on any sclk edge.
    logic [2:0] rx_sck;
    logic [2:0] rx_sdt;
    logic [7:0] rx_sh;
    int         rx_n;
    logic [7:0] rx_q[$];

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_sck <= '0;
            rx_sdt <= '0;
            rx_sh  <= '0;
            rx_n   <= 0;
        end else begin
            rx_sck <= {rx_sck[1:0], sclk};
            rx_sdt <= {rx_sdt[1:0], sdata};
            if (rx_sck[2] ^ rx_sck[1]) begin
                rx_sh <= {rx_sh[6:0], rx_sdt[1]};
                if (rx_n == 7) begin
                    rx_n <= 0;
                    rx_q.push_back({rx_sh[6:0], rx_sdt[1]});
                end else begin
                    rx_n <= rx_n + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one byte and check every cycle from accept edge T to T+80.
    // Called just after a negedge; returns at the negedge after edge T+80.
    task automatic send_byte(input logic [7:0] b, input int restart_k, input bit keep);
        int   n;
        int   tog;
        int   j;
        logic rdy;
        bit   exp_done;
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        #1 rdy = in_ready;
        while (!rdy && n < 400) begin
            @(negedge clk);
            #1 rdy = in_ready;
            n++;
        end
        check("accept_wait", 32'(rdy), 32'd1);
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
        sent_q.push_back(b);
        exp_done = (exp_count + 1 == TB_TOTAL);
        for (int k = 0; k <= 80; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1 restart = 1'b0;
            end
            @(negedge clk);
            tog = (k < 4) ? 0 : ((k - 4) / 8 + 1);
            if (tog > 8) tog = 8;
            j = k / 8;
            if (j > 7) j = 7;
            check("sclk", 32'(sclk), 32'(tog % 2));
            check("sdata", 32'(sdata), 32'(b[7-j]));
            check("busy", 32'(busy), 32'(k < 80));
            check("in_ready", 32'(in_ready), 32'((k == 80) && !exp_done));
            if (k == 0) begin
                check("byte_count_start", 32'(byte_count), 32'(exp_count));
                check("done_start", 32'(done), 32'd0);
            end
            if (k == 80) begin
                check("byte_count_end", 32'(byte_count), 32'(exp_count + 1));
                check("done_end", 32'(done), 32'(exp_done));
            end
            if (k == restart_k) restart = 1'b1;
        end
        exp_count++;
        $display("tx byte %02h sent, byte_count expected %0d", b, exp_count);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        exp_count = 0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rb;
        resetn   = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        restart  = 1'b0;
        #2 resetn = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_sdata", 32'(sdata), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_byte_count", 32'(byte_count), 32'd0);
`ifdef BRAM_SERIAL_TX_TARGET_RST_EN
        check("rst_target_rst", 32'(target_rst), 32'd1);
`endif
        resetn = 1'b1;
        @(negedge clk);
`ifndef BRAM_SERIAL_TX_TARGET_RST_EN
        check("idle_ready", 32'(in_ready), 32'd1);
`endif

        // Single byte 0xA5, then back-to-back 0x00, 0xFF, 0x3C filling the image
        send_byte(8'hA5, -1, 1'b0);
        send_byte(8'h00, -1, 1'b1);
        send_byte(8'hFF, -1, 1'b1);
        send_byte(8'h3C, -1, 1'b1);

        // DONE: in_valid still asserted and must be ignored
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("done_in_ready", 32'(in_ready), 32'd0);
            check("done_busy", 32'(busy), 32'd0);
            check("done_flag", 32'(done), 32'd1);
            check("done_count", 32'(byte_count), 32'(TB_TOTAL));
        end
        in_valid = 1'b0;
        $display("image complete, restarting");

        // restart from DONE
        pulse_restart();
        check("restart_done", 32'(done), 32'd0);
        check("restart_count", 32'(byte_count), 32'd0);
`ifdef BRAM_SERIAL_TX_TARGET_RST_EN
        check("restart_in_ready", 32'(in_ready), 32'd0);
`else
        check("restart_in_ready", 32'(in_ready), 32'd1);
`endif

        // restart during HOLD of bit index 3 is ignored
        send_byte(8'h5A, 37, 1'b0);

        // restart together with in_valid in IDLE: no accept
        restart  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h11;
        #1 check("restart_vs_valid_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        restart  = 1'b0;
        in_valid = 1'b0;
        exp_count = 0;
        @(negedge clk);
        check("restart_vs_valid_busy", 32'(busy), 32'd0);
        check("restart_vs_valid_count", 32'(byte_count), 32'd0);
        check("restart_vs_valid_sclk", 32'(sclk), 32'd0);
        $display("restart in IDLE honoured, byte 11 not accepted");

        // Random bytes through the receiver model
        for (int i = 0; i < 16; i++) begin
            rb = 8'($urandom_range(0, 255));
            send_byte(rb, -1, 1'b0);
            if (exp_count == TB_TOTAL) pulse_restart();
        end

        // Mid-byte reset
        in_data  = 8'hC3;
        in_valid = 1'b1;
        for (int n = 0; n < 400 && !in_ready; n++) @(negedge clk);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_sclk", 32'(sclk), 32'd0);
        check("mid_rst_sdata", 32'(sdata), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_count", 32'(byte_count), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        exp_count = 0;
        $display("mid-byte reset applied");
`ifdef BRAM_SERIAL_TX_TARGET_RST_EN
        #1;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            check("pre_rst_target_rst", 32'(target_rst), 32'(c < 8));
            check("pre_rst_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        check("pre_rst_exit_ready", 32'(in_ready), 32'd1);
        check("pre_rst_exit_target_rst", 32'(target_rst), 32'd0);
`else
        @(negedge clk);
        check("mid_rst_release_ready", 32'(in_ready), 32'd1);
`endif
        send_byte(8'h96, -1, 1'b0);

        // Receiver captured exactly what was sent
        repeat (8) @(negedge clk);
        check("rx_count", 32'(rx_q.size()), 32'(sent_q.size()));
        for (int i = 0; i < sent_q.size() && i < rx_q.size(); i++) begin
            check("rx_byte", 32'(rx_q[i]), 32'(sent_q[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
